// File: rtl/uart_rx_if.sv
// Byte-side handshake bundle of the 8N1 serial receiver.
// The receiver drives the byte and status pulses; the consumer drives data_ready.
interface uart_rx_if;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       frame_err;
    logic       overrun;

    modport master (
        output data_out,
        output data_valid,
        output frame_err,
        output overrun,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_valid,
        input  frame_err,
        input  overrun,
        output data_ready
    );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 LSB-first serial receiver with mid-bit sampling and a
// one-entry valid/ready holding register for the received byte.
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       rx_in,
    uart_rx_if.master  bus
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    logic          sync1_q;
    logic          rx_s_q;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic [7:0]    dout_q;
    logic          valid_q;
    logic          ferr_q;
    logic          ovr_q;

    logic          expire_d;
    logic          done_d;
    logic          accept_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rx_in;
            rx_s_q  <= sync1_q;
        end
    end

    always_comb begin
        expire_d = (cnt_q == '0);
        done_d   = ena && (state_q == STOP) && expire_d && rx_s_q;
        accept_d = valid_q && bus.data_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;

            // A completed byte may refill the register in the cycle it drains.
            if (done_d) begin
                if (!valid_q || accept_d) begin
                    dout_q  <= shift_q;
                    valid_q <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (accept_d) begin
                valid_q <= 1'b0;
            end

            if (!ena) begin
                state_q <= IDLE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (!rx_s_q) begin
                            state_q <= START;
                            cnt_q   <= HALF_M1;
                        end
                    end
                    START: begin
                        if (!expire_d) begin
                            cnt_q <= cnt_q - CW'(1);
                        end else if (rx_s_q) begin
                            state_q <= IDLE;
                        end else begin
                            state_q <= DATA;
                            cnt_q   <= FULL_M1;
                            idx_q   <= '0;
                        end
                    end
                    DATA: begin
                        if (!expire_d) begin
                            cnt_q <= cnt_q - CW'(1);
                        end else begin
                            shift_q[idx_q] <= rx_s_q;
                            cnt_q          <= FULL_M1;
                            if (idx_q == 3'd7) begin
                                state_q <= STOP;
                            end else begin
                                idx_q <= idx_q + 3'd1;
                            end
                        end
                    end
                    STOP: begin
                        if (!expire_d) begin
                            cnt_q <= cnt_q - CW'(1);
                        end else if (rx_s_q) begin
                            state_q <= IDLE;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= BREAK;
                        end
                    end
                    BREAK: begin
                        if (rx_s_q) begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.data_out   = dout_q;
    assign bus.data_valid = valid_q;
    assign bus.frame_err  = ferr_q;
    assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Scoreboard bench for uart_rx_byte: frames are driven bit by bit and
// each expected byte/pulse is queued with the exact cycle it must appear.
module tb_uart_rx_byte;

    localparam int C   = 16;
    localparam int LAT = 154;
    localparam int EV_BYTE = 1;
    localparam int EV_FERR = 2;
    localparam int EV_OVR  = 3;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t sbq[$];

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic ena   = 1'b1;
    logic rx_in = 1'b1;
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    logic       pdv = 1'b0;
    logic [7:0] pdo = 8'h00;

    uart_rx_if bus ();

    uart_rx_byte #(.CLKS_PER_BIT(C)) dut (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .rx_in (rx_in),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int kind, input logic [7:0] d, input int c);
        exp_t e;
        e.kind = kind;
        e.data = d;
        e.cyc  = c;
        sbq.push_back(e);
    endtask

    task automatic observe(input int kind, input logic [7:0] d);
        exp_t e;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL event: got kind=%0d data=%02h cyc=%0d, required none",
                     kind, d, cyc);
        end else begin
            e = sbq.pop_front();
            if (e.kind != kind || e.cyc != cyc ||
                (kind == EV_BYTE && e.data != d)) begin
                errors++;
                $display("FAIL event: got kind=%0d data=%02h cyc=%0d, required kind=%0d data=%02h cyc=%0d",
                         kind, d, cyc, e.kind, e.data, e.cyc);
            end
        end
    endtask

    // Monitor: a new byte, or any status pulse, is one output event.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.data_valid && (!pdv || bus.data_out != pdo))
                observe(EV_BYTE, bus.data_out);
            if (bus.frame_err)
                observe(EV_FERR, 8'h00);
            if (bus.overrun)
                observe(EV_OVR, 8'h00);
        end
        pdv = bus.data_valid;
        pdo = bus.data_out;
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %02h, required %02h", name, act, req);
        end
    endtask

    // Called at a negedge; the next posedge is t0. Leaves rx_in at the stop value.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int kind);
        rx_in = 1'b0;
        if (kind != 0)
            push(kind, b, cyc + 1 + LAT);
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            repeat (C) @(negedge clk);
        end
        rx_in = stop;
        repeat (C) @(negedge clk);
    endtask

    task automatic ack();
        bus.data_ready = 1'b1;
        @(negedge clk);
        bus.data_ready = 1'b0;
    endtask

    initial begin
        bus.data_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset data_out", bus.data_out, 8'h00);
        chk("reset data_valid", {7'd0, bus.data_valid}, 8'h00);
        chk("reset frame_err", {7'd0, bus.frame_err}, 8'h00);
        chk("reset overrun", {7'd0, bus.overrun}, 8'h00);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Byte held until accepted, then cleared on the handshake edge.
        send_frame(8'hA5, 1'b1, EV_BYTE);
        repeat (20) @(negedge clk);
        chk("held data_valid", {7'd0, bus.data_valid}, 8'h01);
        chk("held data_out", bus.data_out, 8'hA5);
        bus.data_ready = 1'b1;
        @(negedge clk);
        chk("ack clears valid", {7'd0, bus.data_valid}, 8'h00);
        bus.data_ready = 1'b0;
        repeat (5) @(negedge clk);

        // Short glitch is rejected; the next frame is clean.
        rx_in = 1'b0;
        repeat (4) @(negedge clk);
        rx_in = 1'b1;
        repeat (30) @(negedge clk);
        send_frame(8'h5A, 1'b1, EV_BYTE);
        repeat (5) @(negedge clk);
        ack();
        repeat (5) @(negedge clk);

        // Low stop bit with the line held low: one frame error only.
        send_frame(8'h3C, 1'b0, EV_FERR);
        repeat (40) @(negedge clk);
        chk("ferr no valid", {7'd0, bus.data_valid}, 8'h00);
        rx_in = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'h81, 1'b1, EV_BYTE);
        repeat (5) @(negedge clk);
        ack();
        repeat (5) @(negedge clk);

        // Back-to-back with nobody consuming: overrun, first byte kept.
        send_frame(8'h11, 1'b1, EV_BYTE);
        send_frame(8'h22, 1'b1, EV_OVR);
        repeat (3) @(negedge clk);
        chk("overrun keeps data", bus.data_out, 8'h11);
        chk("overrun keeps valid", {7'd0, bus.data_valid}, 8'h01);
        ack();
        repeat (5) @(negedge clk);

        // Consumer drains exactly at the second stop sample: no overrun.
        fork
            begin
                send_frame(8'h11, 1'b1, EV_BYTE);
                send_frame(8'h22, 1'b1, EV_BYTE);
            end
            begin
                repeat (10 * C + LAT) @(negedge clk);
                bus.data_ready = 1'b1;
                @(negedge clk);
                bus.data_ready = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        chk("refill data_out", bus.data_out, 8'h22);
        chk("refill data_valid", {7'd0, bus.data_valid}, 8'h01);

        // Reset during data bit 3 of 0xFF.
        fork
            send_frame(8'hFF, 1'b1, 0);
            begin
                repeat (70) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                chk("midrst data_out", bus.data_out, 8'h00);
                chk("midrst data_valid", {7'd0, bus.data_valid}, 8'h00);
                chk("midrst frame_err", {7'd0, bus.frame_err}, 8'h00);
                chk("midrst overrun", {7'd0, bus.overrun}, 8'h00);
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
        join
        repeat (10) @(negedge clk);
        send_frame(8'h42, 1'b1, EV_BYTE);
        repeat (5) @(negedge clk);

        // Disable mid-frame: frame dropped, handshake still honoured.
        fork
            send_frame(8'h99, 1'b1, 0);
            begin
                repeat (40) @(negedge clk);
                ena = 1'b0;
                repeat (5) @(negedge clk);
                bus.data_ready = 1'b1;
                @(negedge clk);
                chk("ena0 handshake", {7'd0, bus.data_valid}, 8'h00);
                bus.data_ready = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        chk("ena0 no byte", {7'd0, bus.data_valid}, 8'h00);
        ena = 1'b1;
        repeat (10) @(negedge clk);
        send_frame(8'h7E, 1'b1, EV_BYTE);
        repeat (30) @(negedge clk);

        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d pending events, required 0",
                     sbq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_byte.md
# uart_rx_byte

Asynchronous serial (8N1, LSB first) receiver that turns the single-bit serial input taken from a dedicated input pin (`ui_in[0]`) of the TinyTapeout top into bytes. It presents each byte to the downstream core over a one-entry valid/ready holding register. It is the input stage directly upstream of the user core logic inside the top module, and reports framing errors and overruns as single-cycle pulses.

## Interface
- `CLKS_PER_BIT`, 16: clocks per serial bit; must be even and ≥ 4.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ena`  in  1  block enable; low forces the receive FSM to IDLE.
- `rx_in`  in  1  raw serial line, idle high, asynchronous to `clk`.
- `data_out`  out  8  received byte; valid while `data_valid`=1.
- `data_valid`  out  1  holding register full.
- `data_ready`  in  1  consumer accepts byte when `data_valid & data_ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: byte completed while holding register full and not being accepted.

## Operation
- `rx_in` passes through a 2-flop synchronizer; both flops reset to 1. FSM uses the synchronized value `rx_s` only.
- States: IDLE, START, DATA, STOP, BREAK. Down-counter sized for `CLKS_PER_BIT`-1; 3-bit bit index; 8-bit shift register.
- IDLE: when `rx_s`=0 → START, counter = `CLKS_PER_BIT/2`-1.
- START: at counter expiry, sample `rx_s`. If 1 (glitch) → IDLE, no outputs. If 0 → DATA, counter = `CLKS_PER_BIT`-1, index = 0.
- DATA: at each expiry, shift `rx_s` into bit [index] (LSB first), reload counter. After bit 7 → STOP.
- STOP: at expiry, sample `rx_s`. If 1: byte complete → IDLE. If 0: `frame_err` pulses, byte discarded → BREAK.
- BREAK: wait until `rx_s`=1, then → IDLE (a held-low line produces exactly one `frame_err`).
- Holding register, on byte completion:
  - empty, or accepted in the same cycle (`data_valid & data_ready`): load `data_out`; `data_valid` = 1.
  - full and not accepted: `overrun` pulses; new byte dropped; `data_out` unchanged.
- Handshake with no completion: `data_valid & data_ready` clears `data_valid` on that edge. `data_out` holds its last value.
- `ena`=0: FSM → IDLE on the next edge; any in-flight frame is discarded. Synchronizer and holding register keep running and retain state. `data_ready` handshakes are still honoured.
- Reset values: `data_out`=0x00, `data_valid`=0, `frame_err`=0, `overrun`=0, FSM=IDLE, synchronizer=1. Reset asserted mid-frame aborts the frame. The first falling edge after release starts a fresh frame.

## Timing
- C=`CLKS_PER_BIT`, H=C/2.
- Let t0 be the edge at which sync flop 1 first captures 0. `rx_s`=0 at t0+1. FSM enters START at edge t0+2 (E).
- Samples: start bit at E+H; data bit i at E+H+(i+1)·C; stop bit at E+H+9·C.
- `data_valid` rises, or `frame_err`/`overrun` pulses, on the stop-sample edge. Total latency t0 → `data_valid` = H+9C+2 cycles (154 at C=16).
- Earliest next frame: a start edge is recognised in IDLE on the cycle after stop sampling. Back-to-back frames with no extra idle time are received.
- `frame_err` and `overrun` are high for exactly one cycle. They are never both high.
- Bit sampling is at mid-bit. Tolerates ±(H-2)/(10·C) baud mismatch (about ±3.7% at C=16).

## Test plan
- C=16, send 0xA5 with `data_ready`=0 → `data_valid`=1 and `data_out`=0xA5 at t0+154 and held. Pulse `data_ready` for one cycle → `data_valid`=0 on that edge.
- Drive `rx_in` low for 4 cycles then high → no `data_valid` and no `frame_err`; a following 0x5A frame is received correctly.
- Send 0x3C with the stop bit low, line held low 40 cycles → one `frame_err` pulse, `data_valid` stays 0. Then send 0x81 → received as 0x81.
- Send 0x11 then 0x22 back-to-back with `data_ready`=0 → `overrun` pulses at the second stop sample; `data_out` stays 0x11.
- Repeat with `data_ready`=1 only on the second stop-sample cycle → no `overrun`; `data_out`=0x22 and `data_valid` stays 1.
- Assert `rst` during data bit 3 of 0xFF → all outputs at reset values. After release, send 0x42 → received as 0x42. Drop `ena` during a frame → no byte is produced.
